regfile_wb_controller: RTL and testbench

// - Owns the single write port of the 2**AW x DW register file; shares it among NREQ writeback requesters (ALU, LSU, ...).
// - Round-robin arbitration; a one-stage write pipeline drives the register file write port.
// - Per-register busy scoreboard; presents hazard-qualified read data to decode.
// - Sits between the execute/writeback units and the register file.

---
 rtl/regfile_wb_controller_if.sv | 15 +
 rtl/regfile_wb_controller.sv | 117 +++++++++++
 tb/tb_regfile_wb_controller.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_controller_if.sv
// Writeback requester bus: NREQ packed valid/addr/data lanes plus the one-hot grant back.
// The requester side drives the master modport; the controller consumes the slave modport.
interface regfile_wb_controller_if #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;

  modport master (output req_valid, req_addr, req_data, input  req_ready);
  modport slave  (input  req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_controller.sv
// Register-file write-port owner: round-robin writeback arbiter, 1-cycle write stage, busy scoreboard.
// Latency 1 (grant -> rf write); one-hot ready, losers hold; optional WB_BYPASS_EN forwards the staged write.
module regfile_wb_controller #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREQ = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wb_controller_if.slave wb,
  input  logic                   issue_valid,
  input  logic [AW-1:0]          issue_rd,
  input  logic [AW-1:0]          src1_addr,
  input  logic [AW-1:0]          src2_addr,
  input  logic [DW-1:0]          rf_rd_data1,
  input  logic [DW-1:0]          rf_rd_data2,
  output logic [AW-1:0]          rf_rd_addr1,
  output logic [AW-1:0]          rf_rd_addr2,
  output logic [DW-1:0]          src1_data,
  output logic [DW-1:0]          src2_data,
  output logic                   src1_busy,
  output logic                   src2_busy,
  output logic                   rf_wr_en,
  output logic [AW-1:0]          rf_wr_addr,
  output logic [DW-1:0]          rf_wr_data
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 2 ** AW;

  typedef struct packed {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_stage_t;

  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   grant_idx;
  logic [NREQ-1:0] grant;
  logic            grant_any;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  wr_stage_t       stage_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Search upward from the requester after the last winner; first valid one wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = last_grant;
    grant_any = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant) + off) % NREQ;
      if (!grant_any && wb.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign wb.req_ready = grant;
  assign sel_addr     = wb.req_addr[int'(grant_idx)*AW +: AW];
  assign sel_data     = wb.req_data[int'(grant_idx)*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IW'(NREQ - 1);
      stage_q    <= '0;
    end else begin
      stage_q.en <= grant_any && (sel_addr != '0);
      if (grant_any) begin
        last_grant   <= grant_idx;
        stage_q.addr <= sel_addr;
        stage_q.data <= sel_data;
      end
    end
  end

  // Gating with rst_n keeps a write staged just before reset from reaching the file.
  assign rf_wr_en   = stage_q.en & rst_n;
  assign rf_wr_addr = stage_q.addr;
  assign rf_wr_data = stage_q.data;

  // Clear first so a same-cycle issue to the retiring register re-marks it busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_wr_en)    busy_d[rf_wr_addr] = 1'b0;
    if (issue_valid) busy_d[issue_rd]   = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Returns {busy, data} for one decode read port.
  function automatic logic [DW:0] read_port(input logic [AW-1:0] a, input logic [DW-1:0] rd);
    logic hit;
    hit = 1'b0;
`ifdef WB_BYPASS_EN
    hit = rf_wr_en && (a == rf_wr_addr);
`endif
    if (a == '0) return '0;
    if (hit)     return {1'b0, rf_wr_data};
    return {busy_q[a], rd};
  endfunction

  assign rf_rd_addr1 = src1_addr;
  assign rf_rd_addr2 = src2_addr;
  assign {src1_busy, src1_data} = read_port(src1_addr, rf_rd_data1);
  assign {src2_busy, src2_data} = read_port(src2_addr, rf_rd_data2);

endmodule

// File: tb/tb_regfile_wb_controller.sv
// Directed bench for regfile_wb_controller: reset, RR grants, scoreboard, x0, hazards, reset drop.
module tb_regfile_wb_controller;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_controller_if #(.AW(AW), .DW(DW), .NREQ(NREQ)) wb ();

  logic          issue_valid;
  logic [AW-1:0] issue_rd, src1_addr, src2_addr, rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2, src1_data, src2_data, rf_wr_data;
  logic          src1_busy, src2_busy, rf_wr_en;
  logic          mem_clr;
  logic [DW-1:0] rf_mem [2**AW];

  regfile_wb_controller #(.AW(AW), .DW(DW), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .wb(wb),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .src1_addr(src1_addr), .src2_addr(src2_addr),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .src1_data(src1_data), .src2_data(src2_data),
    .src1_busy(src1_busy), .src2_busy(src2_busy),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data)
  );

  // Register file model; x0 returns garbage so the controller must force zero itself.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 2**AW; i++) rf_mem[i] <= '0;
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end
  assign rf_rd_data1 = (rf_rd_addr1 == '0) ? 32'hFFFF_FFFF : rf_mem[rf_rd_addr1];
  assign rf_rd_data2 = (rf_rd_addr2 == '0) ? 32'hFFFF_FFFF : rf_mem[rf_rd_addr2];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb.req_valid[i]         = v;
    wb.req_addr[i*AW +: AW] = a;
    wb.req_data[i*DW +: DW] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    mem_clr      = 1'b1;
    wb.req_valid = '0;
    wb.req_addr  = '0;
    wb.req_data  = '0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    src1_addr    = 5'd5;
    src2_addr    = 5'd7;
    set_req(0, 1'b1, 5'd3, 32'hA000_0003);
    set_req(1, 1'b1, 5'd4, 32'hB000_0004);

    // Reset held for two cycles with both requesters valid
    repeat (2) next_cycle();
    mem_clr = 1'b0;
    @(negedge clk);
    check("rst_wr_en", 32'(rf_wr_en), 32'd0);
    check("rst_ready", 32'(wb.req_ready), 32'h1);
    check("rst_busy1", 32'(src1_busy), 32'd0);
    check("rst_busy2", 32'(src2_busy), 32'd0);

    // Round robin, both valid for six cycles
    next_cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("rr_ready%0d", k), 32'(wb.req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      if (k > 0) begin
        check($sformatf("rr_wr_en%0d", k), 32'(rf_wr_en), 32'd1);
        check($sformatf("rr_wr_addr%0d", k), 32'(rf_wr_addr), (k % 2 == 1) ? 32'd3 : 32'd4);
        check($sformatf("rr_wr_data%0d", k), rf_wr_data, (k % 2 == 1) ? 32'hA000_0003 : 32'hB000_0004);
      end
      next_cycle();
    end
    wb.req_valid = '0;
    src2_addr    = 5'd4;
    @(negedge clk);
    check("rr_last_wr_en", 32'(rf_wr_en), 32'd1);
    check("rr_last_addr", 32'(rf_wr_addr), 32'd4);
    check("rr_idle_ready", 32'(wb.req_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("rr_x4_data", src2_data, 32'hB000_0004);
    check("rr_idle_wr_en", 32'(rf_wr_en), 32'd0);

    // Scoreboard: issue x5, then writeback x5
    next_cycle();
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    src1_addr   = 5'd5;
    @(negedge clk);
    check("sb_busy_pre", 32'(src1_busy), 32'd0);
    next_cycle();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check("sb_ready", 32'(wb.req_ready), 32'h1);
    check("sb_busy_n", 32'(src1_busy), 32'd1);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("sb_wr_en_n1", 32'(rf_wr_en), 32'd1);
    check("sb_wr_addr_n1", 32'(rf_wr_addr), 32'd5);
`ifdef WB_BYPASS_EN
    check("sb_busy_n1", 32'(src1_busy), 32'd0);
    check("sb_data_n1", src1_data, 32'hDEAD_BEEF);
`else
    check("sb_busy_n1", 32'(src1_busy), 32'd1);
`endif
    next_cycle();
    @(negedge clk);
    check("sb_busy_n2", 32'(src1_busy), 32'd0);
    check("sb_data_n2", src1_data, 32'hDEAD_BEEF);

    // x0: write to x0 is accepted but never reaches the file
    next_cycle();
    set_req(1, 1'b1, 5'd0, 32'h0000_1234);
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    src1_addr   = 5'd0;
    @(negedge clk);
    check("x0_ready", 32'(wb.req_ready), 32'h2);
    check("x0_data", src1_data, 32'd0);
    check("x0_busy", 32'(src1_busy), 32'd0);
    next_cycle();
    set_req(1, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0;
    @(negedge clk);
    check("x0_wr_en", 32'(rf_wr_en), 32'd0);
    check("x0_busy_after", 32'(src1_busy), 32'd0);

    // Hazard: re-issue x7 in the cycle its write retires
    next_cycle();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    src1_addr   = 5'd7;
    next_cycle();
    issue_valid = 1'b0;
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    @(negedge clk);
    check("hz_ready", 32'(wb.req_ready), 32'h1);
    check("hz_busy_n", 32'(src1_busy), 32'd1);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    @(negedge clk);
    check("hz_wr_en", 32'(rf_wr_en), 32'd1);
    check("hz_wr_addr", 32'(rf_wr_addr), 32'd7);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    check("hz_busy_kept", 32'(src1_busy), 32'd1);
    check("hz_data", src1_data, 32'h0000_0077);

    // Reset in the cycle after a transfer drops the staged write
    next_cycle();
    set_req(0, 1'b1, 5'd9, 32'h0000_5555);
    @(negedge clk);
    check("rd_ready", 32'(wb.req_ready), 32'h1);
    next_cycle();
    set_req(0, 1'b0, 5'd0, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rd_wr_en", 32'(rf_wr_en), 32'd0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    set_req(0, 1'b1, 5'd3, 32'h1);
    set_req(1, 1'b1, 5'd4, 32'h2);
    @(negedge clk);
    check("rd_mem9", rf_mem[9], 32'd0);
    check("rd_busy7", 32'(src1_busy), 32'd0);
    check("rd_ready_after", 32'(wb.req_ready), 32'h1);
    next_cycle();
    wb.req_valid = '0;
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
